// File: rtl/aligner_pkg.sv
// aligner_pkg: base codes, sizes, FSM states and mismatch scoring shared by the candidate scorer
package aligner_pkg;
  localparam int BASE_W = 2;
  localparam logic [BASE_W-1:0] BASE_A = 2'b00;
  localparam logic [BASE_W-1:0] BASE_G = 2'b01;
  localparam logic [BASE_W-1:0] BASE_C = 2'b10;
  localparam logic [BASE_W-1:0] BASE_T = 2'b11;
  localparam int READ_BASES = 8;
  localparam int WIN_BASES = 10;
  localparam int IDX_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SCORE, REPORT} state_t;
  function automatic logic [3:0] base_mismatch_count(
    input logic [BASE_W*READ_BASES-1:0] read,
    input logic [BASE_W*WIN_BASES-1:0] window,
    input logic [1:0] shift
  );
    logic [BASE_W*READ_BASES-1:0] w;
    logic [3:0] n;
    w = (BASE_W*READ_BASES)'(window >> (BASE_W * shift));
    n = '0;
    for (int i = 0; i < READ_BASES; i++)
      n = n + 4'(read[BASE_W*i +: BASE_W] != w[BASE_W*i +: BASE_W]);
    return n;
  endfunction
endpackage

// File: rtl/cand_fifo.sv
// cand_fifo: synchronous candidate FIFO with flush, occupancy count and full/empty flags
module cand_fifo #(
  parameter int W = 28,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(D);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/candidate_scorer.sv
// candidate_scorer: scores buffered reference windows against a short read and reports the best hit
module candidate_scorer
  import aligner_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_MISMATCH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BASE_W*READ_BASES-1:0]  shortread,
  input  logic                          cand_valid,
  output logic                          cand_ready,
  input  logic [IDX_W-1:0]              cand_index,
  input  logic [BASE_W*WIN_BASES-1:0]   cand_sequence,
  input  logic                          stream_end,
  output logic                          best_valid,
  output logic [IDX_W-1:0]              best_index,
  output logic [3:0]                    best_mismatch,
  output logic                          best_found,
  output logic                          busy
);
  localparam int CW = IDX_W + BASE_W*WIN_BASES;
  localparam int SHIFTS = WIN_BASES - READ_BASES + 1;
  state_t state, nxt;
  logic [BASE_W*READ_BASES-1:0] rd;
  logic [IDX_W-1:0] w_idx;
  logic [BASE_W*WIN_BASES-1:0] w_seq;
  logic [1:0] s;
  logic [3:0] score;
  logic [CW-1:0] head;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic end_pending, full, empty, last;
  cand_fifo #(.W(CW), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .clear(start), .push(cand_valid && !full), .pop(state == LOAD),
    .din({cand_index, cand_sequence}), .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign cand_ready = count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);
  assign score = base_mismatch_count(rd, w_seq, s);
  assign best_found = best_mismatch <= 4'(MAX_MISMATCH);
  always_comb begin
    last = state == SCORE && s == 2'(SHIFTS-1);
    nxt = state == LOAD ? SCORE :
          state == REPORT ? IDLE :
          (state == SCORE && !last) ? SCORE :
          !empty ? LOAD :
          end_pending ? REPORT : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rd <= '0;
      w_idx <= '0;
      w_seq <= '0;
      s <= '0;
      end_pending <= 1'b0;
      busy <= 1'b0;
      best_valid <= 1'b0;
      best_index <= '0;
      best_mismatch <= 4'hF;
    end else if (start) begin
      state <= IDLE;
      rd <= shortread;
      end_pending <= 1'b0;
      busy <= 1'b1;
      best_valid <= 1'b0;
      best_index <= '0;
      best_mismatch <= 4'hF;
    end else begin
      state <= nxt;
      best_valid <= nxt == REPORT;
      end_pending <= (end_pending || stream_end) && state != REPORT;
      if (nxt == REPORT) busy <= 1'b0;
      if (state == LOAD) begin
        {w_idx, w_seq} <= head;
        s <= '0;
      end
      if (state == SCORE) begin
        s <= s + 2'd1;
        if (score < best_mismatch) begin
          best_mismatch <= score;
          best_index <= w_idx + IDX_W'(s);
        end
      end
    end
endmodule

// File: tb/tb_candidate_scorer.sv
// tb_candidate_scorer: directed scenario tests for candidate_scorer with hand-computed expectations
module tb_candidate_scorer;
  logic clk = 0, reset, start, cand_valid, stream_end;
  logic [15:0] shortread;
  logic [7:0] cand_index, best_index;
  logic [19:0] cand_sequence;
  logic cand_ready, best_valid, best_found, busy;
  logic [3:0] best_mismatch;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  candidate_scorer dut (
    .clk(clk), .reset(reset), .start(start), .shortread(shortread),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_index(cand_index),
    .cand_sequence(cand_sequence), .stream_end(stream_end), .best_valid(best_valid),
    .best_index(best_index), .best_mismatch(best_mismatch), .best_found(best_found), .busy(busy)
  );

  task automatic begin_read(input logic [15:0] sr);
    shortread = sr;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push(input logic [7:0] idx, input logic [19:0] seq);
    int n = 0;
    cand_valid = 1;
    cand_index = idx;
    cand_sequence = seq;
    while (!cand_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cand_valid = 0;
  endtask

  task automatic end_read(output int cyc);
    stream_end = 1;
    @(negedge clk);
    stream_end = 0;
    cyc = 0;
    while (!best_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({cand_ready, best_valid, busy} !== 3'b100) $display("FAIL reset_ctrl: ready/valid/busy=%b want 100", {cand_ready, best_valid, busy});
    else passed++;
    total++;
    if ({best_index, best_mismatch, best_found} !== {8'd0, 4'hF, 1'b0}) $display("FAIL reset_best: idx=%0d mm=%h found=%b want idx=0 mm=f found=0", best_index, best_mismatch, best_found);
    else passed++;
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_exact;
    int cyc;
    begin_read(16'hE4E4);
    total++;
    if (busy !== 1'b1) $display("FAIL exact_busy_start: busy=%b want 1", busy);
    else passed++;
    push(8'd10, 20'h0E4E4);
    end_read(cyc);
    total++;
    if (best_valid !== 1'b1 || cyc != 4) $display("FAIL exact_latency: valid=%b cycles=%0d want valid=1 cycles=4", best_valid, cyc);
    else passed++;
    total++;
    if ({best_index, best_mismatch, best_found} !== {8'd10, 4'd0, 1'b1}) $display("FAIL exact_best: idx=%0d mm=%0d found=%b want idx=10 mm=0 found=1", best_index, best_mismatch, best_found);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL exact_busy_end: busy=%b want 0", busy);
    else passed++;
    @(negedge clk);
    total++;
    if (best_valid !== 1'b0 || best_index !== 8'd10) $display("FAIL exact_hold: valid=%b idx=%0d want valid=0 idx=10", best_valid, best_index);
    else passed++;
  endtask

  task automatic test_shift;
    int cyc;
    begin_read(16'hE4E4);
    push(8'd20, 20'hE4E40);
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch, best_found} !== {1'b1, 8'd22, 4'd0, 1'b1}) $display("FAIL shift_best: valid=%b idx=%0d mm=%0d found=%b want 1/22/0/1", best_valid, best_index, best_mismatch, best_found);
    else passed++;
    begin_read(16'hE4E4);
    push(8'd255, 20'hE4E40);
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch} !== {1'b1, 8'd1, 4'd0}) $display("FAIL shift_wrap: valid=%b idx=%0d mm=%0d want 1/1/0", best_valid, best_index, best_mismatch);
    else passed++;
  endtask

  task automatic test_reject_tie;
    int cyc;
    begin_read(16'h0000);
    push(8'd5, 20'hFFFFF);
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch, best_found} !== {1'b1, 8'd5, 4'd8, 1'b0}) $display("FAIL reject_tie: valid=%b idx=%0d mm=%0d found=%b want 1/5/8/0", best_valid, best_index, best_mismatch, best_found);
    else passed++;
    begin_read(16'h0000);
    push(8'd5, 20'hFFFFF);
    push(8'd40, 20'h00000);
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch, best_found} !== {1'b1, 8'd40, 4'd0, 1'b1}) $display("FAIL reject_second: valid=%b idx=%0d mm=%0d found=%b want 1/40/0/1", best_valid, best_index, best_mismatch, best_found);
    else passed++;
  endtask

  task automatic test_threshold;
    int cyc;
    begin_read(16'h0000);
    push(8'd30, 20'h50005);
    end_read(cyc);
    total++;
    if ({best_index, best_mismatch, best_found} !== {8'd30, 4'd2, 1'b1}) $display("FAIL thresh_two: idx=%0d mm=%0d found=%b want 30/2/1", best_index, best_mismatch, best_found);
    else passed++;
    begin_read(16'h0000);
    push(8'd31, 20'h50105);
    end_read(cyc);
    total++;
    if ({best_index, best_mismatch, best_found} !== {8'd31, 4'd3, 1'b0}) $display("FAIL thresh_three: idx=%0d mm=%0d found=%b want 31/3/0", best_index, best_mismatch, best_found);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc, n;
    bit saw_full = 0;
    begin_read(16'h0000);
    for (int k = 0; k < 8; k++) begin
      cand_valid = 1;
      cand_index = 8'(100 + k);
      cand_sequence = k == 5 ? 20'h00000 : k == 7 ? 20'h50005 : 20'hFFFFF;
      n = 0;
      while (!cand_ready && n < 100) begin
        saw_full = 1;
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    cand_valid = 0;
    total++;
    if (saw_full !== 1'b1) $display("FAIL bp_ready_low: saw_full=%b want 1", saw_full);
    else passed++;
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch, best_found} !== {1'b1, 8'd105, 4'd0, 1'b1}) $display("FAIL bp_best: valid=%b idx=%0d mm=%0d found=%b want 1/105/0/1", best_valid, best_index, best_mismatch, best_found);
    else passed++;
  endtask

  task automatic test_empty_stream;
    int cyc;
    begin_read(16'h1234);
    end_read(cyc);
    total++;
    if (best_valid !== 1'b1 || cyc > 3) $display("FAIL empty_timing: valid=%b cycles=%0d want valid=1 cycles<=3", best_valid, cyc);
    else passed++;
    total++;
    if ({best_index, best_mismatch, best_found, busy} !== {8'd0, 4'hF, 1'b0, 1'b0}) $display("FAIL empty_best: idx=%0d mm=%h found=%b busy=%b want 0/f/0/0", best_index, best_mismatch, best_found, busy);
    else passed++;
  endtask

  task automatic test_abort;
    int cyc;
    begin_read(16'h0000);
    push(8'd60, 20'h00000);
    repeat (2) @(negedge clk);
    begin_read(16'h0000);
    push(8'd70, 20'hFFFFF);
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch} !== {1'b1, 8'd70, 4'd8}) $display("FAIL abort_best: valid=%b idx=%0d mm=%0d want 1/70/8", best_valid, best_index, best_mismatch);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc, pulses = 0;
    begin_read(16'hE4E4);
    push(8'd10, 20'h0E4E4);
    repeat (4) @(negedge clk);
    total++;
    if (best_mismatch !== 4'd0 || busy !== 1'b1) $display("FAIL rstmid_pre: mm=%0d busy=%b want 0/1", best_mismatch, busy);
    else passed++;
    reset = 1;
    #1;
    total++;
    if ({cand_ready, busy, best_mismatch, best_valid} !== {1'b1, 1'b0, 4'hF, 1'b0}) $display("FAIL rstmid_async: ready=%b busy=%b mm=%h valid=%b want 1/0/f/0", cand_ready, busy, best_mismatch, best_valid);
    else passed++;
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (best_valid) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL rstmid_no_pulse: pulses=%0d want 0", pulses);
    else passed++;
    begin_read(16'hE4E4);
    push(8'd12, 20'h0E4E4);
    end_read(cyc);
    total++;
    if ({best_valid, best_index, best_mismatch, best_found} !== {1'b1, 8'd12, 4'd0, 1'b1}) $display("FAIL rstmid_after: valid=%b idx=%0d mm=%0d found=%b want 1/12/0/1", best_valid, best_index, best_mismatch, best_found);
    else passed++;
  endtask

  initial begin
    reset = 1;
    start = 0;
    cand_valid = 0;
    stream_end = 0;
    shortread = '0;
    cand_index = '0;
    cand_sequence = '0;
    test_reset;
    test_exact;
    test_shift;
    test_reject_tie;
    test_threshold;
    test_back_to_back;
    test_empty_stream;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
